// File: rtl/rr_dequeue.sv
// rtl/rr_dequeue.sv - dequeue stage between the round-robin arbiter and its FIFO bank
// Pops the selected FIFO, captures its word one cycle later, and counts dequeues per queue.
module rr_dequeue #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8,
  parameter int COUNT_BITS     = 8,
  localparam int SEL_BITS      = $clog2(QUEUE_QUANTITY)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enb,
  input  logic                                 pause,
  input  logic [SEL_BITS-1:0]                  selector,
  input  logic                                 selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]            buf_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0]  fifo_data,
  output logic [QUEUE_QUANTITY-1:0]            pop,
  output logic                                 rr_advance,
  output logic [DATA_BITS-1:0]                 data_out,
  output logic [SEL_BITS-1:0]                  data_src,
  output logic                                 valid_out,
  output logic [QUEUE_QUANTITY*COUNT_BITS-1:0] dq_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t               state;
  logic [SEL_BITS-1:0]  sel_q;
  logic [COUNT_BITS-1:0] cnt_q [QUEUE_QUANTITY];
  logic [DATA_BITS-1:0] fifo_word [QUEUE_QUANTITY];
  logic                 start_ok;

  for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_lanes
    assign fifo_word[g]                             = fifo_data[g*DATA_BITS +: DATA_BITS];
    assign dq_count[g*COUNT_BITS +: COUNT_BITS]     = cnt_q[g];
  end

  // An empty selected FIFO must never be popped, even if the arbiter offers it.
  assign start_ok = enb && !pause && selector_enb && !buf_empty[selector];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel_q      <= '0;
      pop        <= '0;
      rr_advance <= 1'b0;
      data_out   <= '0;
      data_src   <= '0;
      valid_out  <= 1'b0;
      for (int i = 0; i < QUEUE_QUANTITY; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            pop        <= QUEUE_QUANTITY'(1) << selector;
            rr_advance <= 1'b1;
            sel_q      <= selector;
            state      <= READ;
          end else begin
            pop        <= '0;
            rr_advance <= 1'b0;
          end
        end
        READ: begin
          pop        <= '0;
          rr_advance <= 1'b0;
          state      <= LATCH;
        end
        LATCH: begin
          // The FIFO word for sel_q is on fifo_data now: one cycle after its pop.
          data_out     <= fifo_word[sel_q];
          data_src     <= sel_q;
          valid_out    <= 1'b1;
          cnt_q[sel_q] <= cnt_q[sel_q] + COUNT_BITS'(1);
          state        <= IDLE;
        end
        default: begin
          pop        <= '0;
          rr_advance <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_dequeue.sv
// tb/tb_rr_dequeue.sv - directed vector bench for rr_dequeue
// Drives a latency-1 FIFO model and checks registered outputs after each edge.
module tb_rr_dequeue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic        pause;
  logic [1:0]  selector;
  logic        selector_enb;
  logic [3:0]  buf_empty;
  logic [31:0] fifo_data;
  logic [3:0]  pop;
  logic        rr_advance;
  logic [7:0]  data_out;
  logic [1:0]  data_src;
  logic        valid_out;
  logic [31:0] dq_count;

  int tests_run = 0;
  int tests_failed = 0;

  rr_dequeue #(.QUEUE_QUANTITY(4), .DATA_BITS(8), .COUNT_BITS(8)) dut (
    .clk(clk), .rst(rst), .enb(enb), .pause(pause), .selector(selector),
    .selector_enb(selector_enb), .buf_empty(buf_empty), .fifo_data(fifo_data),
    .pop(pop), .rr_advance(rr_advance), .data_out(data_out), .data_src(data_src),
    .valid_out(valid_out), .dq_count(dq_count)
  );

  always #5 clk = ~clk;

  // FIFO bank model: queue i returns base[i]+n for its n-th pop, one cycle after pop[i].
  localparam logic [7:0] BASE [4] = '{8'h10, 8'h40, 8'hA5, 8'hC0};
  logic [7:0] rd_cnt [4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data <= {4{8'hEE}};
      for (int i = 0; i < 4; i++) rd_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pop[i]) begin
          fifo_data[i*8 +: 8] <= BASE[i] + rd_cnt[i];
          rd_cnt[i]           <= rd_cnt[i] + 8'd1;
        end
      end
    end
  end

  typedef struct {
    logic        enb;
    logic        pause;
    logic        senb;
    logic [1:0]  sel;
    logic [3:0]  empty;
    logic [3:0]  pop;
    logic        adv;
    logic        valid;
    logic [1:0]  src;
    logic [7:0]  data;
    logic [31:0] cnt;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_pop, input logic e_adv,
                           input logic e_valid, input logic [1:0] e_src,
                           input logic [7:0] e_data, input logic [31:0] e_cnt);
    check({tag, ".pop"}, 32'(pop), 32'(e_pop));
    check({tag, ".rr_advance"}, 32'(rr_advance), 32'(e_adv));
    check({tag, ".valid_out"}, 32'(valid_out), 32'(e_valid));
    check({tag, ".data_src"}, 32'(data_src), 32'(e_src));
    check({tag, ".data_out"}, 32'(data_out), 32'(e_data));
    check({tag, ".dq_count"}, dq_count, e_cnt);
  endtask

  initial begin
    //          enb  pause senb sel   empty   pop     adv   valid src   data   cnt {c3,c2,c1,c0}
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd0, 8'h00, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'h00000000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5, 32'h00010000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hA5, 32'h00010000};
    // start held continuously; selector wanders while busy and must be ignored
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd2, 8'hA5, 32'h00010000};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hA5, 32'h00010000};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h10, 32'h00010001};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0010, 1'b1, 1'b0, 2'd0, 8'h10, 32'h00010001};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h10, 32'h00010001};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1, 8'h40, 32'h00010101};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0100, 1'b1, 1'b0, 2'd1, 8'h40, 32'h00010101};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 8'h40, 32'h00010101};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA6, 32'h00020101};
    // pause: blocks in IDLE, does not abort an operation in flight
    vecs[14] = '{1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hA6, 32'h00020101};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b1000, 1'b1, 1'b0, 2'd2, 8'hA6, 32'h00020101};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hA6, 32'h00020101};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3, 8'hC0, 32'h01020101};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'hC0, 32'h01020101};
    // empty selected FIFO, no selection, stage disabled, then a lone non-empty queue
    vecs[19] = '{1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd3, 8'hC0, 32'h01020101};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'hC0, 32'h01020101};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'hC0, 32'h01020101};
    vecs[22] = '{1'b1, 1'b0, 1'b1, 2'd0, 4'b1110, 4'b0001, 1'b1, 1'b0, 2'd3, 8'hC0, 32'h01020101};
    vecs[23] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 8'hC0, 32'h01020101};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h11, 32'h01020102};

    rst = 1'b1; enb = 1'b0; pause = 1'b0; selector = 2'd0;
    selector_enb = 1'b0; buf_empty = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    check_all("reset", 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      enb = vecs[i].enb; pause = vecs[i].pause; selector_enb = vecs[i].senb;
      selector = vecs[i].sel; buf_empty = vecs[i].empty;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].pop, vecs[i].adv, vecs[i].valid,
                vecs[i].src, vecs[i].data, vecs[i].cnt);
    end

    // asynchronous reset while in LATCH aborts the word
    enb = 1'b1; pause = 1'b0; selector_enb = 1'b1; selector = 2'd1; buf_empty = 4'b0000;
    @(posedge clk); #1;
    check("abort.pop", 32'(pop), 32'h2);
    enb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("abort.async", 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort.valid%0d", k), 32'(valid_out), 32'h0);
      check($sformatf("abort.cnt%0d", k), dq_count, 32'h0);
    end

    // 256 dequeues from queue 3: counter wraps, other fields untouched
    selector = 2'd3; selector_enb = 1'b1; buf_empty = 4'b0000; pause = 1'b0;
    for (int n = 0; n < 256; n++) begin
      enb = 1'b1;
      @(posedge clk); #1;
      check($sformatf("wrap.pop%0d", n), 32'(pop), 32'h8);
      enb = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check($sformatf("wrap.cnt%0d", n), dq_count, {8'(n + 1), 24'h0});
    end
    check("wrap.final_cnt", dq_count, 32'h0);
    check("wrap.final_data", 32'(data_out), 32'hBF);
    check("wrap.final_src", 32'(data_src), 32'h3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
